// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: R-type funct codes, I-type opcodes,
// the NOP ALUop, divider states and the store byte-lane helpers.
package exe_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [5:0]  OP_NOP       = 6'b111111;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // I-type opcodes; 001001 doubles as the generic "add" ALUop
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest;
    logic        memtoreg;
    logic [5:0]  aluop;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
  } exe_bundle_t;

  function automatic logic [3:0] store_wen(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   store_wen = 4'b0001 << a;
      OP_SH:   store_wen = a[1] ? 4'b1100 : 4'b0011;
      OP_SW:   store_wen = 4'b1111;
      default: store_wen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   store_wdata = {4{rt[7:0]}};
      OP_SH:   store_wdata = {2{rt[15:0]}};
      default: store_wdata = rt;
    endcase
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// Iterative radix-2 restoring divider (IDLE -> RUN x DIV_CYCLES -> DONE) with
// sign handling for DIV and the divide-by-zero convention LO=all-ones, HI=dividend.
module div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(DIV_CYCLES) + 1;

  div_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0] r, q, d, raw;
  logic        neg_q, neg_r, dz;
  logic [32:0] shifted, diff;

  always_comb begin
    shifted = {r, q[31]};
    diff    = shifted - {1'b0, d};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      raw   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          q     <= (signed_op && dividend[31]) ? ~dividend + 32'd1 : dividend;
          d     <= (signed_op && divisor[31])  ? ~divisor + 32'd1  : divisor;
          r     <= '0;
          raw   <= dividend;
          neg_q <= signed_op & (dividend[31] ^ divisor[31]);
          neg_r <= signed_op & dividend[31];
          dz    <= (divisor == 32'd0);
          cnt   <= '0;
          state <= DIV_RUN;
        end
        DIV_RUN: begin
          // a borrow out of the trial subtract means the shifted remainder stays
          if (!diff[32]) begin
            r <= diff[31:0];
            q <= {q[30:0], 1'b1};
          end else begin
            r <= shifted[31:0];
            q <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = ((state == DIV_IDLE) && start) || (state == DIV_RUN);
  assign done      = (state == DIV_DONE);
  assign quotient  = dz ? 32'hFFFFFFFF : (neg_q ? ~q + 32'd1 : q);
  assign remainder = dz ? raw : (neg_r ? ~r + 32'd1 : r);

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: stage register, ALU, data-SRAM request, HI/LO and the
// iterative divider that stalls the front of the pipe.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ID_pc_out,
  input  logic [31:0] ID_inst_out,
  input  logic [4:0]  ID_dest_out,
  input  logic        ID_memtoreg_out,
  input  logic [5:0]  ID_ALUop_out,
  input  logic [31:0] ID_vsrc1_out,
  input  logic [31:0] ID_vsrc2_out,
  input  logic [31:0] ID_reg_rt_out,
  input  logic        ID_HI_we_out,
  input  logic        ID_LO_we_out,
  output logic        EXE_busy,
  output logic [31:0] EXE_pc,
  output logic [31:0] EXE_inst,
  output logic [4:0]  EXE_dest,
  output logic        EXE_memtoreg,
  output logic [31:0] EXE_result,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);
  exe_bundle_t st, id_b;
  logic        rtype, is_mul, is_div, is_store, div_busy, div_done;
  logic [31:0] sum, div_q, div_r;
  logic [63:0] a64, b64, prod;

  assign id_b = '{pc: ID_pc_out, inst: ID_inst_out, dest: ID_dest_out,
                  memtoreg: ID_memtoreg_out, aluop: ID_ALUop_out,
                  v1: ID_vsrc1_out, v2: ID_vsrc2_out, rt: ID_reg_rt_out,
                  hi_we: ID_HI_we_out, lo_we: ID_LO_we_out};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st       <= '0;
      st.pc    <= RESET_PC;
      st.aluop <= OP_NOP;
    end else if (!EXE_busy) begin
      st <= id_b;
    end
  end

  // funct and opcode spaces overlap, so the instruction's opcode field picks one
  assign rtype    = (st.inst[31:26] == 6'b000000);
  assign is_mul   = rtype && (st.aluop == F_MULT || st.aluop == F_MULTU);
  assign is_div   = rtype && (st.aluop == F_DIV  || st.aluop == F_DIVU);
  assign is_store = !rtype && (st.aluop == OP_SB || st.aluop == OP_SH || st.aluop == OP_SW);
  assign sum      = st.v1 + st.v2;

  always_comb begin
    EXE_result = '0;
    if (st.aluop == OP_ADDIU) EXE_result = sum;
    else if (rtype) begin
      case (st.aluop)
        F_ADD, F_ADDU:   EXE_result = sum;
        F_SUB, F_SUBU:   EXE_result = st.v1 - st.v2;
        F_AND:           EXE_result = st.v1 & st.v2;
        F_OR:            EXE_result = st.v1 | st.v2;
        F_XOR:           EXE_result = st.v1 ^ st.v2;
        F_NOR:           EXE_result = ~(st.v1 | st.v2);
        F_SLT:           EXE_result = {31'b0, $signed(st.v1) < $signed(st.v2)};
        F_SLTU:          EXE_result = {31'b0, st.v1 < st.v2};
        F_SLL, F_SLLV:   EXE_result = st.v2 << st.v1[4:0];
        F_SRL, F_SRLV:   EXE_result = st.v2 >> st.v1[4:0];
        F_SRA, F_SRAV:   EXE_result = $unsigned($signed(st.v2) >>> st.v1[4:0]);
        default:         EXE_result = '0;
      endcase
    end else begin
      case (st.aluop)
        OP_ADDI:  EXE_result = sum;
        OP_SLTI:  EXE_result = {31'b0, $signed(st.v1) < $signed(st.v2)};
        OP_SLTIU: EXE_result = {31'b0, st.v1 < st.v2};
        OP_ANDI:  EXE_result = st.v1 & st.v2;
        OP_ORI:   EXE_result = st.v1 | st.v2;
        OP_XORI:  EXE_result = st.v1 ^ st.v2;
        OP_LUI:   EXE_result = {st.v2[15:0], 16'h0};
        default:  EXE_result = (st.memtoreg || is_store) ? sum : '0;
      endcase
    end
  end

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact
  always_comb begin
    a64  = (st.aluop == F_MULT) ? {{32{st.v1[31]}}, st.v1} : {32'b0, st.v1};
    b64  = (st.aluop == F_MULT) ? {{32{st.v2[31]}}, st.v2} : {32'b0, st.v2};
    prod = a64 * b64;
  end

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (is_div),
    .signed_op (st.aluop == F_DIV),
    .dividend  (st.v1),
    .divisor   (st.v2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      HI <= '0;
      LO <= '0;
    end else if (div_done) begin
      HI <= div_r;
      LO <= div_q;
    end else if (is_mul) begin
      HI <= prod[63:32];
      LO <= prod[31:0];
    end else begin
      if (st.hi_we) HI <= st.v1;
      if (st.lo_we) LO <= st.v1;
    end
  end

  assign EXE_busy        = div_busy;
  assign EXE_pc          = EXE_busy ? RESET_PC : st.pc;
  assign EXE_inst        = EXE_busy ? '0 : st.inst;
  assign EXE_dest        = EXE_busy ? '0 : st.dest;
  assign EXE_memtoreg    = EXE_busy ? 1'b0 : st.memtoreg;
  assign data_sram_en    = !EXE_busy && (st.memtoreg || is_store);
  assign data_sram_wen   = (!EXE_busy && is_store) ? store_wen(st.aluop, sum[1:0]) : 4'b0000;
  assign data_sram_addr  = sum;
  assign data_sram_wdata = store_wdata(st.aluop, st.rt);

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the decode stage's registered-out bundle (ALUop, operands, dest, mem/HI/LO controls).
- Computes the ALU result and issues the data-SRAM request for loads/stores.
- Owns the HI/LO registers, updated by MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Stalls upstream while an iterative divide runs.

Parameters:
- RESET_PC, 32'hbfc00000, PC loaded into the stage register on reset/bubble.
- DIV_CYCLES, 32, iterations of the radix-2 divider.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ID_pc_out  in  32  PC of instruction leaving decode
- ID_inst_out  in  32  instruction word (zero = bubble)
- ID_dest_out  in  5  destination GPR, 0 = none
- ID_memtoreg_out  in  1  load
- ID_ALUop_out  in  6  op code (funct for R-type, opcode for I-type, 001001 = add, 111111 = none)
- ID_vsrc1_out  in  32  operand 1
- ID_vsrc2_out  in  32  operand 2
- ID_reg_rt_out  in  32  store data
- ID_HI_we_out  in  1  MTHI
- ID_LO_we_out  in  1  MTLO
- EXE_busy  out  1  divide in progress; upstream must hold and ID must not advance
- EXE_pc, EXE_inst  out  32 each  to MEM
- EXE_dest  out  5  to MEM / hazard unit
- EXE_memtoreg  out  1  to MEM
- EXE_result  out  32  ALU result; also the EXE_for forwarding value
- HI, LO  out  32 each  architectural HI/LO, read by decode for MFHI/MFLO
- data_sram_en  out  1  memory request
- data_sram_wen  out  4  byte strobes
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

Behaviour:
- Reset (resetn=0 at posedge):
  - EXE_pc = RESET_PC; EXE_inst, EXE_dest, EXE_memtoreg = 0.
  - HI = LO = 0; divider state returns to IDLE, aborting any divide in progress.
  - Reset overrides a simultaneous MTHI/MTLO or divider DONE.
- Stage register: loads all ID_*_out fields every posedge when EXE_busy=0 and holds them when EXE_busy=1. ID already supplies bubbles (inst=0, dest=0, ALUop=111111) when it stalls.
- ALU (combinational on the stage register; result = vsrc2 shifted/combined with vsrc1):
  - Add/subtract: ADD/ADDU/ADDI/ADDIU/001001 → v1+v2; SUB/SUBU → v1−v2. No overflow traps in this lab.
  - Logic: AND/ANDI, OR/ORI, XOR/XORI, NOR.
  - Compare: SLT/SLTI signed, SLTU/SLTIU unsigned, result 0 or 1.
  - Shifts: SLL/SLLV → v2 << v1[4:0]; SRL/SRLV logical right; SRA/SRAV arithmetic right.
  - LUI → {v2[15:0],16'h0}.
  - 111111 and the multiply/divide ops → result 0.
- Memory request (asserted only when the stage holds a load or store and EXE_busy=0):
  - addr = v1+v2; wdata = reg_rt replicated per size.
  - SW: wen 1111.
  - SH: wen 0011 or 1100 by addr[1]; wdata {2{rt[15:0]}}.
  - SB: wen = one-hot of addr[1:0]; wdata {4{rt[7:0]}}.
  - Loads: en=1, wen=0000.
  - SWL/SWR: en=0 (deferred to a later lab).
- Multiply (MULT/MULTU): single cycle; {HI,LO} = signed/unsigned 64-bit product, written at the end of the EXE cycle. Never sets busy.
- MTHI/MTLO: HI or LO ← vsrc1 at the end of the EXE cycle.
- Divide FSM (DIV/DIVU), states IDLE, RUN, DONE:
  - IDLE with a divide in the stage: busy=1; load the dividend/divisor magnitudes and sign flags; counter=0; go to RUN.
  - RUN: one restoring step per cycle, busy=1; after DIV_CYCLES steps go to DONE.
  - DONE: busy=0; LO = quotient, HI = remainder, sign-corrected for DIV (quotient negative if signs differ, remainder takes the dividend's sign); stage advances at this edge; return to IDLE.
  - Occupancy is 1+DIV_CYCLES busy cycles plus one DONE cycle, i.e. 34 EXE cycles for the default.
  - Divisor zero: LO = 32'hFFFFFFFF, HI = raw dividend, same timing.
- Outputs while busy:
  - EXE_dest=0, EXE_memtoreg=0, data_sram_en=0, EXE_inst=0, EXE_pc=RESET_PC, so MEM sees bubbles.
  - EXE_result is still valid for forwarding but tagged dest 0.
- HI/LO write priority within one cycle: reset > divide DONE > MULT/MULTU > MTHI/MTLO. These cannot legally coincide except with reset.

Decomposition:
- Shared header (existing head.h) carries the funct/opcode ALUop constants (ADD, SLT, SRA, MULT, DIV, SB, SH, SW, …), the NOP ALUop 6'b111111, and RESET_PC.
- Sub-module div_iter (clk, resetn, start, signed_op, dividend, divisor → busy, done, quotient, remainder) implements the FSM and restoring datapath. ALU and store-strobe logic stay inline.

Test Plan:
- ADDU v1=5, v2=7, dest=3 → EXE_result=12, EXE_dest=3 one cycle later, data_sram_en=0.
- SRA v1=4, v2=32'h80000000 → EXE_result=32'hF8000000; SLTU v1=1, v2=32'hFFFFFFFF → 1.
- SB v1=32'h1000, v2=3, rt=32'h000000AB → addr 32'h1003, wen 1000, wdata 32'hABABABAB.
- MULT 32'hFFFFFFFF×2 → HI=32'hFFFFFFFF, LO=32'hFFFFFFFE; MULTU same operands → HI=1, LO=32'hFFFFFFFE; busy never asserted.
- DIV −7/2 → busy high exactly 33 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; the following instruction enters EXE on the DONE edge; DIVU 7/0 → LO=32'hFFFFFFFF, HI=7.
- Assert resetn=0 on RUN cycle 10 of a divide → next cycle busy=0, HI=LO=0, FSM IDLE, EXE_inst=0.
